seven_seg_scan_driver: RTL

//   Time-multiplexed N-digit 7-segment display driver. Successor to the single-digit combinational

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_encoder.sv | 39 +++
 rtl/seven_seg_scan_driver.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns and blank-mask helper for the 7-segment scan driver
package seg7_pkg;

  // Patterns are {a,b,c,d,e,f,g}, written with 0 = segment lit
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0001100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam int MAX_DIGITS = 8;

  // Walks from the most significant digit down; a zero stays suppressed while
  // everything above it is zero or already dark. Digit 0 is never lz-blanked.
  function automatic logic [MAX_DIGITS-1:0] blank_mask(
    input logic [4*MAX_DIGITS-1:0] digits,
    input logic [MAX_DIGITS-1:0]   blank,
    input logic                    lz,
    input int                      num,
    input logic                    hex
  );
    logic       lead;
    logic       expl;
    logic       zero;
    logic [3:0] code;
    blank_mask = '0;
    lead       = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < num) begin
        code          = digits[i*4 +: 4];
        expl          = blank[i] | (!hex && (code > 4'd9));
        zero          = (code == 4'd0);
        blank_mask[i] = expl | (lz && lead && zero && (i != 0));
        lead          = lead & (zero | expl);
      end
    end
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// rtl/seg7_encoder.sv - 4-bit code to 7-segment pattern, with hex and polarity options
module seg7_encoder
  import seg7_pkg::*;
#(
  parameter int HEX_MODE   = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] code,
  output logic [6:0] seg
);

  logic [6:0] raw;

  always_comb begin
    raw = SEG_OFF;
    case (code)
      4'h0: raw = SEG_0;
      4'h1: raw = SEG_1;
      4'h2: raw = SEG_2;
      4'h3: raw = SEG_3;
      4'h4: raw = SEG_4;
      4'h5: raw = SEG_5;
      4'h6: raw = SEG_6;
      4'h7: raw = SEG_7;
      4'h8: raw = SEG_8;
      4'h9: raw = SEG_9;
      4'hA: raw = (HEX_MODE != 0) ? SEG_A : SEG_OFF;
      4'hB: raw = (HEX_MODE != 0) ? SEG_B : SEG_OFF;
      4'hC: raw = (HEX_MODE != 0) ? SEG_C : SEG_OFF;
      4'hD: raw = (HEX_MODE != 0) ? SEG_D : SEG_OFF;
      4'hE: raw = (HEX_MODE != 0) ? SEG_E : SEG_OFF;
      4'hF: raw = (HEX_MODE != 0) ? SEG_F : SEG_OFF;
      default: raw = SEG_OFF;
    endcase
  end

  assign seg = (ACTIVE_LOW != 0) ? raw : ~raw;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed N-digit 7-segment driver with double-buffered capture
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HEX_MODE    = 0,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic          POL     = (ACTIVE_LOW != 0);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          tick;
  logic          wrap;

  logic [4*NUM_DIGITS-1:0] pend_digits, disp_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, disp_blank;
  logic                    pend_lz, disp_lz;

  assign tick = (cnt == CNT_MAX);
  assign wrap = tick && (idx == IDX_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      frame_done <= wrap;
      if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  // Display only changes at the frame boundary; a load in that same cycle bypasses pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_lz     <= 1'b0;
      disp_digits <= '0;
      disp_dp     <= '0;
      disp_blank  <= '0;
      disp_lz     <= 1'b0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_blank  <= blank_in;
        pend_lz     <= lz_suppress;
      end
      if (wrap) begin
        disp_digits <= load ? digits_in   : pend_digits;
        disp_dp     <= load ? dp_in       : pend_dp;
        disp_blank  <= load ? blank_in    : pend_blank;
        disp_lz     <= load ? lz_suppress : pend_lz;
      end
    end
  end

  logic [4*MAX_DIGITS-1:0] digits_ext;
  logic [MAX_DIGITS-1:0]   blank_ext;
  logic [MAX_DIGITS-1:0]   bmask;
  logic [3:0]              cur_code;
  logic                    cur_blank;
  logic [6:0]              enc_seg;
  logic [NUM_DIGITS-1:0]   onehot;

  always_comb begin
    digits_ext                   = '0;
    blank_ext                    = '0;
    digits_ext[4*NUM_DIGITS-1:0] = disp_digits;
    blank_ext[NUM_DIGITS-1:0]    = disp_blank;
  end

  assign bmask     = blank_mask(digits_ext, blank_ext, disp_lz, NUM_DIGITS, HEX_MODE != 0);
  assign cur_code  = disp_digits[4*int'(idx) +: 4];
  assign cur_blank = bmask[3'(idx)];
  assign onehot    = NUM_DIGITS'(1) << idx;

  seg7_encoder #(
    .HEX_MODE  (HEX_MODE),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_encoder (
    .code(cur_code),
    .seg (enc_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NUM_DIGITS{POL}};
    end else if (cur_blank) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NUM_DIGITS{POL}};
    end else begin
      seg <= enc_seg;
      dp  <= disp_dp[idx] ^ POL;
      an  <= POL ? ~onehot : onehot;
    end
  end

endmodule
